// File: rtl/ccsds_123b2_selftest_scheduler.sv
// Shares one ccsds_123b2 core between the user stream and the selftest ROMs, handing it over only at image boundaries.
// Optional AUTO_SELFTEST_EN: raises a selftest request after AUTO_PERIOD idle cycles.
module ccsds_123b2_selftest_scheduler #(
    parameter int TEST_WORDS     = 61200,
    parameter int REF_WORDS      = 4881,
    parameter int TIMEOUT_CYCLES = 220000,
    parameter int AUTO_PERIOD    = 1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        test_req,
    input  logic [15:0] usr_in_d,
    input  logic        usr_in_valid,
    input  logic        usr_in_last,
    output logic        usr_in_ready,
    input  logic [15:0] tst_in_d,
    input  logic        tst_in_valid,
    output logic        tst_in_ready,
    output logic [15:0] core_in_d,
    output logic        core_in_valid,
    input  logic        core_in_ready,
    input  logic [63:0] core_out_data,
    input  logic        core_out_valid,
    input  logic        core_out_last,
    output logic        core_out_ready,
    output logic [63:0] usr_out_data,
    output logic        usr_out_valid,
    output logic        usr_out_last,
    input  logic        usr_out_ready,
    input  logic [63:0] ref_data,
    input  logic        ref_valid,
    output logic        ref_ready,
    output logic        busy,
    output logic        test_active,
    output logic        test_pass,
    output logic        test_fail,
    output logic        test_timeout,
    output logic [15:0] test_count
);
    // state      | meaning
    // IDLE       | core free; selftest request wins over a waiting user image
    // USER_RUN   | user samples stream into the core
    // USER_DRAIN | user input closed, waiting for core_out_last
    // TEST_RUN   | test ROM streams in, output checked against reference ROM
    // TEST_DRAIN | test input done, still checking until core_out_last
    // ERROR      | timed out; only rst leaves
    typedef enum logic [2:0] {IDLE, USER_RUN, USER_DRAIN, TEST_RUN, TEST_DRAIN, ERROR} state_t;

    localparam logic [31:0] TEST_LAST = 32'(TEST_WORDS - 1);
    localparam logic [31:0] REF_LAST  = 32'(REF_WORDS - 1);
    localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 1);

    state_t      state, state_next;
    logic        pending, req_any, grant, publish, timeout_hit, auto_hit;
    logic        chk_xfer, fail_int, fail_now;
    logic [31:0] in_cnt, ref_cnt, tmo_cnt;

    assign usr_out_data = core_out_data;
    assign busy         = (state != IDLE);
    assign test_active  = (state == TEST_RUN) || (state == TEST_DRAIN);
    assign req_any      = pending | test_req;
    assign chk_xfer     = test_active & core_out_valid & ref_valid;
    assign timeout_hit  = test_active & (tmo_cnt == TMO_LAST);

    // Folds in the current transfer so the published result includes the final compare.
    assign fail_now = fail_int | (chk_xfer & ((core_out_data != ref_data) |
                      (core_out_last ? (ref_cnt != REF_LAST) : (ref_cnt == REF_LAST))));

`ifdef AUTO_SELFTEST_EN
    localparam logic [31:0] AUTO_LAST = 32'(AUTO_PERIOD - 1);
    logic [31:0] idle_cnt;

    assign auto_hit = (state == IDLE) && !pending && (idle_cnt == AUTO_LAST);

    always_ff @(posedge clk) begin
        if (rst || state != IDLE || pending) idle_cnt <= '0;
        else                                 idle_cnt <= idle_cnt + 32'd1;
    end
`else
    assign auto_hit = 1'b0;
`endif

    always_comb begin
        state_next     = state;
        grant          = 1'b0;
        publish        = 1'b0;
        usr_in_ready   = 1'b0;
        tst_in_ready   = 1'b0;
        core_in_d      = '0;
        core_in_valid  = 1'b0;
        core_out_ready = 1'b0;
        usr_out_valid  = 1'b0;
        usr_out_last   = 1'b0;
        ref_ready      = 1'b0;
        case (state)
            IDLE: begin
                if (req_any) begin
                    grant      = 1'b1;
                    state_next = TEST_RUN;
                end else if (usr_in_valid) begin
                    state_next = USER_RUN;
                end
            end
            USER_RUN, USER_DRAIN: begin
                core_out_ready = usr_out_ready;
                usr_out_valid  = core_out_valid;
                usr_out_last   = core_out_last;
                if (state == USER_RUN) begin
                    core_in_d     = usr_in_d;
                    core_in_valid = usr_in_valid;
                    usr_in_ready  = core_in_ready;
                    if (usr_in_valid && core_in_ready && usr_in_last) state_next = USER_DRAIN;
                end else if (core_out_valid && usr_out_ready && core_out_last) begin
                    state_next = IDLE;
                end
            end
            TEST_RUN, TEST_DRAIN: begin
                core_out_ready = ref_valid;
                ref_ready      = core_out_valid & ref_valid;
                if (state == TEST_RUN) begin
                    core_in_d     = tst_in_d;
                    core_in_valid = tst_in_valid;
                    tst_in_ready  = core_in_ready;
                    if (tst_in_valid && core_in_ready && in_cnt == TEST_LAST) state_next = TEST_DRAIN;
                end
                if (chk_xfer && core_out_last) begin
                    publish    = 1'b1;
                    state_next = IDLE;
                end
                if (timeout_hit) begin
                    publish    = 1'b0;
                    state_next = ERROR;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            pending      <= 1'b0;
            in_cnt       <= '0;
            ref_cnt      <= '0;
            tmo_cnt      <= '0;
            fail_int     <= 1'b0;
            test_pass    <= 1'b0;
            test_fail    <= 1'b0;
            test_timeout <= 1'b0;
            test_count   <= '0;
        end else begin
            state   <= state_next;
            pending <= (pending | test_req | auto_hit) & ~grant;
            if (grant) begin
                in_cnt       <= '0;
                ref_cnt      <= '0;
                tmo_cnt      <= '0;
                fail_int     <= 1'b0;
                test_pass    <= 1'b0;
                test_fail    <= 1'b0;
                test_timeout <= 1'b0;
            end else if (test_active) begin
                tmo_cnt <= tmo_cnt + 32'd1;
                if (tst_in_valid && tst_in_ready) in_cnt <= in_cnt + 32'd1;
                if (chk_xfer) begin
                    ref_cnt  <= ref_cnt + 32'd1;
                    fail_int <= fail_now;
                end
                if (timeout_hit) begin
                    test_timeout <= 1'b1;
                    test_fail    <= 1'b1;
                end else if (publish) begin
                    test_pass <= ~fail_now;
                    test_fail <= fail_now;
                    if (test_count != 16'hFFFF) test_count <= test_count + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_ccsds_123b2_selftest_scheduler.sv
// Randomized bench for the selftest scheduler: a transaction-level model of core ownership predicts every output each cycle.
module tb_ccsds_123b2_selftest_scheduler;
    localparam int TW  = 8;
    localparam int RW  = 3;
    localparam int TMO = 50;
    localparam int AP  = 20;

    logic        clk = 1'b0;
    logic        rst, test_req;
    logic [15:0] usr_in_d, tst_in_d, core_in_d;
    logic        usr_in_valid, usr_in_last, usr_in_ready, tst_in_valid, tst_in_ready;
    logic        core_in_valid, core_in_ready;
    logic [63:0] core_out_data, usr_out_data, ref_data;
    logic        core_out_valid, core_out_last, core_out_ready;
    logic        usr_out_valid, usr_out_last, usr_out_ready, ref_valid, ref_ready;
    logic        busy, test_active, test_pass, test_fail, test_timeout;
    logic [15:0] test_count;

    always #5 clk = ~clk;

    ccsds_123b2_selftest_scheduler #(
        .TEST_WORDS(TW), .REF_WORDS(RW), .TIMEOUT_CYCLES(TMO), .AUTO_PERIOD(AP)
    ) dut (
        .clk(clk), .rst(rst), .test_req(test_req),
        .usr_in_d(usr_in_d), .usr_in_valid(usr_in_valid), .usr_in_last(usr_in_last), .usr_in_ready(usr_in_ready),
        .tst_in_d(tst_in_d), .tst_in_valid(tst_in_valid), .tst_in_ready(tst_in_ready),
        .core_in_d(core_in_d), .core_in_valid(core_in_valid), .core_in_ready(core_in_ready),
        .core_out_data(core_out_data), .core_out_valid(core_out_valid), .core_out_last(core_out_last),
        .core_out_ready(core_out_ready),
        .usr_out_data(usr_out_data), .usr_out_valid(usr_out_valid), .usr_out_last(usr_out_last),
        .usr_out_ready(usr_out_ready),
        .ref_data(ref_data), .ref_valid(ref_valid), .ref_ready(ref_ready),
        .busy(busy), .test_active(test_active), .test_pass(test_pass), .test_fail(test_fail),
        .test_timeout(test_timeout), .test_count(test_count)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Who owns the core and how far the current image/selftest has progressed.
    typedef enum {M_IDLE, M_USER, M_UDRAIN, M_TEST, M_TDRAIN, M_ERR} owner_t;
    owner_t m_mode;
    bit     m_pend, m_bad, m_pass, m_fail, m_tmo;
    int     m_in, m_ref, m_cyc, m_cnt, m_idle;

    // Stimulus knobs.
    int  p, uimg, usr_left_in, usr_left_out, req_sample, corrupt_idx, last_at, tcyc, err_cnt;
    bit  req_now, req_fired, stall, early_out, rand_mode;

    bit  e_uin_r, e_tin_r, e_cin_v, e_cout_r, e_ref_r, e_uout_v;

    function automatic bit roll(int pct);
        return $urandom_range(99) < pct;
    endfunction

    function automatic bit idle_done();
        return m_mode == M_IDLE && !m_pend && usr_left_in == 0 && usr_left_out == 0;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_pend = 0; m_bad = 0; m_pass = 0; m_fail = 0; m_tmo = 0;
        m_in = 0; m_ref = 0; m_cyc = 0; m_cnt = 0; m_idle = 0;
        usr_left_in = 0; usr_left_out = 0;
    endtask

    task automatic drive();
        rst = rst;
        test_req = req_now;
        if (req_sample >= 0 && !req_fired && m_mode == M_USER && (uimg - usr_left_in) == req_sample) begin
            test_req  = 1'b1;
            req_fired = 1'b1;
        end
        usr_in_valid   = (usr_left_in > 0) && roll(p);
        usr_in_last    = (usr_left_in == 1);
        usr_in_d       = 16'($urandom);
        tst_in_valid   = roll(p);
        tst_in_d       = 16'($urandom);
        core_in_ready  = !stall && roll(p);
        ref_valid      = roll(p);
        ref_data       = {$urandom, $urandom};
        usr_out_ready  = roll(p);
        core_out_data  = {$urandom, $urandom};
        core_out_valid = roll(50);
        core_out_last  = roll(50);
        if (m_mode == M_USER || m_mode == M_UDRAIN) begin
            core_out_valid = usr_left_out > 0 && roll(p) && !(usr_left_out == 1 && usr_left_in > 0);
            core_out_last  = (usr_left_out == 1);
        end else if (m_mode == M_TEST || m_mode == M_TDRAIN) begin
            core_out_valid = (m_mode == M_TDRAIN || (early_out && m_in >= 4)) && roll(p);
            core_out_last  = (m_ref == last_at);
            core_out_data  = (m_ref == corrupt_idx) ? 64'hDEADBEEF00000000 : ref_data;
        end
    endtask

    task automatic model_expect();
        e_uin_r = 0; e_tin_r = 0; e_cin_v = 0; e_cout_r = 0; e_ref_r = 0; e_uout_v = 0;
        if (m_mode == M_USER) begin
            e_cin_v = usr_in_valid; e_uin_r = core_in_ready;
        end
        if (m_mode == M_TEST) begin
            e_cin_v = tst_in_valid; e_tin_r = core_in_ready;
        end
        if (m_mode == M_USER || m_mode == M_UDRAIN) begin
            e_cout_r = usr_out_ready; e_uout_v = core_out_valid;
        end
        if (m_mode == M_TEST || m_mode == M_TDRAIN) begin
            e_cout_r = ref_valid; e_ref_r = core_out_valid & ref_valid;
        end
    endtask

    task automatic check_outputs();
        chk("usr_in_ready", usr_in_ready, e_uin_r);
        chk("tst_in_ready", tst_in_ready, e_tin_r);
        chk("core_in_valid", core_in_valid, e_cin_v);
        if (e_cin_v) chk("core_in_d", core_in_d, (m_mode == M_USER) ? usr_in_d : tst_in_d);
        chk("core_out_ready", core_out_ready, e_cout_r);
        chk("ref_ready", ref_ready, e_ref_r);
        chk("usr_out_valid", usr_out_valid, e_uout_v);
        if (e_uout_v) begin
            chk("usr_out_last", usr_out_last, core_out_last);
            chk("usr_out_data", usr_out_data, core_out_data);
        end
        chk("busy", busy, m_mode != M_IDLE);
        chk("test_active", test_active, m_mode == M_TEST || m_mode == M_TDRAIN);
        chk("test_pass", test_pass, m_pass);
        chk("test_fail", test_fail, m_fail);
        chk("test_timeout", test_timeout, m_tmo);
        chk("test_count", test_count, 64'(m_cnt));
    endtask

    task automatic model_step();
        owner_t old;
        bit grant, auto_hit;
        if (rst) begin
            model_reset();
            return;
        end
        old = m_mode; grant = 0; auto_hit = 0;
`ifdef AUTO_SELFTEST_EN
        if (m_mode == M_IDLE && !m_pend) begin
            if (m_idle == AP - 1) begin auto_hit = 1; m_idle = 0; end
            else m_idle++;
        end else m_idle = 0;
`endif
        case (old)
            M_IDLE: begin
                if (m_pend || test_req) begin
                    grant = 1; m_mode = M_TEST;
                    m_in = 0; m_ref = 0; m_cyc = 0; m_bad = 0;
                    m_pass = 0; m_fail = 0; m_tmo = 0;
                end else if (usr_in_valid) m_mode = M_USER;
            end
            M_USER, M_UDRAIN: begin
                if (core_out_valid && usr_out_ready) begin
                    usr_left_out--;
                    if (core_out_last && old == M_UDRAIN) m_mode = M_IDLE;
                end
                if (old == M_USER && usr_in_valid && core_in_ready) begin
                    usr_left_in--;
                    if (usr_in_last) m_mode = M_UDRAIN;
                end
            end
            M_TEST, M_TDRAIN: begin
                if (m_cyc == TMO - 1) begin
                    m_mode = M_ERR; m_tmo = 1; m_fail = 1;
                end else begin
                    m_cyc++;
                    if (old == M_TEST && tst_in_valid && core_in_ready) begin
                        if (m_in == TW - 1) m_mode = M_TDRAIN;
                        m_in++;
                    end
                    if (core_out_valid && ref_valid) begin
                        if (core_out_data != ref_data) m_bad = 1;
                        if (core_out_last) begin
                            if (m_ref != RW - 1) m_bad = 1;
                            m_pass = !m_bad; m_fail = m_bad;
                            if (m_cnt < 65535) m_cnt++;
                            m_mode = M_IDLE;
                        end else if (m_ref == RW - 1) m_bad = 1;
                        m_ref++;
                    end
                end
            end
            default: ;
        endcase
        m_pend = (m_pend || test_req || auto_hit) && !grant;
        if (rand_mode && old == M_IDLE && m_mode == M_TEST) begin
            corrupt_idx = roll(30) ? $urandom_range(RW - 1) : -1;
            last_at     = roll(70) ? RW - 1 : (roll(50) ? RW - 2 : RW);
        end
    endtask

    task automatic cycle();
        drive();
        #2;
        model_expect();
        check_outputs();
        if (m_mode == M_TEST || m_mode == M_TDRAIN) tcyc++;
        @(posedge clk);
        model_step();
        req_now = 0;
        #1;
    endtask

    task automatic run_until_idle(int budget, string name);
        int k = 0;
        do begin cycle(); k++; end while (!idle_done() && k < budget);
        if (!idle_done()) begin
            n_tests++; n_fail++;
            $display("FAIL %s: still busy after %0d cycles, required idle", name, budget);
        end
    endtask

    task automatic test_run(int corrupt, int last_idx, string name);
        corrupt_idx = corrupt; last_at = last_idx; req_now = 1;
        run_until_idle(200, name);
    endtask

    initial begin
        rst = 1; req_now = 0; stall = 0; p = 90; early_out = 0; rand_mode = 0;
        corrupt_idx = -1; last_at = RW - 1; req_sample = -1; req_fired = 0; uimg = 0; tcyc = 0; err_cnt = 0;
        model_reset();
        drive();
        repeat (2) @(posedge clk);
        #1;
        cycle(); cycle();
        chk("lit_reset_busy", busy, 0);
        chk("lit_reset_count", test_count, 0);
        rst = 0;

        // Matching ROMs: clean pass.
        test_run(-1, RW - 1, "run_pass");
        chk("lit_pass", test_pass, 1);
        chk("lit_pass_fail", test_fail, 0);
        chk("lit_pass_busy", busy, 0);
`ifndef AUTO_SELFTEST_EN
        chk("lit_pass_count", test_count, 1);
`endif
        // Second reference word corrupted.
        test_run(1, RW - 1, "run_corrupt");
        chk("lit_corrupt_fail", test_fail, 1);
        chk("lit_corrupt_pass", test_pass, 0);
`ifndef AUTO_SELFTEST_EN
        chk("lit_corrupt_count", test_count, 2);
`endif
        // User image of 5 with a request during sample 2: test follows the drain.
        uimg = 5; usr_left_in = 5; usr_left_out = 5; req_sample = 2; req_fired = 0;
        corrupt_idx = -1; last_at = RW - 1;
        run_until_idle(300, "run_user_then_test");
        req_sample = -1;
        chk("lit_user_test_pass", test_pass, 1);
`ifndef AUTO_SELFTEST_EN
        chk("lit_user_test_count", test_count, 3);
`endif
        // Request and user valid in the same idle cycle: the test wins.
        uimg = 5; usr_left_in = 5; usr_left_out = 5; req_now = 1; p = 100;
        cycle();
        p = 90;
        chk("lit_simul_grant", test_active, 1);
        run_until_idle(300, "run_simul");

        // Early and late last: both fail.
        test_run(-1, RW - 2, "run_short_last");
        chk("lit_short_fail", test_fail, 1);
        test_run(-1, RW, "run_long_last");
        chk("lit_long_fail", test_fail, 1);

        // Core stalled: timeout after TMO test cycles, then locked until rst.
        stall = 1; req_now = 1; tcyc = 0;
        for (int k = 0; k < 120 && m_mode != M_ERR; k++) cycle();
        chk("lit_tmo_cycles", tcyc, TMO);
        repeat (5) cycle();
        chk("lit_tmo_flag", test_timeout, 1);
        chk("lit_tmo_fail", test_fail, 1);
        chk("lit_tmo_busy", busy, 1);
        chk("lit_tmo_ready", tst_in_ready, 0);
        rst = 1; cycle(); cycle(); rst = 0; stall = 0;
        chk("lit_rst_count", test_count, 0);
        chk("lit_rst_busy", busy, 0);
        chk("lit_rst_tmo", test_timeout, 0);

        // Random mix of images, requests, corruptions and resets.
        rand_mode = 1; early_out = 1; p = 80;
        for (int k = 0; k < 1500; k++) begin
            if (usr_left_in == 0 && usr_left_out == 0 && roll(4)) begin
                uimg = $urandom_range(6, 1); usr_left_in = uimg; usr_left_out = uimg;
            end
            req_now = roll(3);
            err_cnt = (m_mode == M_ERR) ? err_cnt + 1 : 0;
            rst = (err_cnt > 3) || roll(1);
            cycle();
        end
        rst = 0; rand_mode = 0; early_out = 0; p = 90; corrupt_idx = -1; last_at = RW - 1;
        run_until_idle(400, "run_random_tail");

`ifdef AUTO_SELFTEST_EN
        rst = 1; cycle(); rst = 0;
        tcyc = 0;
        begin
            int k = 0;
            while (!m_pend && k < 100) begin cycle(); k++; end
            chk("lit_auto_period", k, AP);
            k = 0;
            while (m_cnt < 3 && k < 600) begin cycle(); k++; end
            chk("lit_auto_count", test_count, 3);
        end
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
